// File: rtl/vga_tile_scan.sv
// vga_tile_scan: 640x480@60 scan engine for the 3x3 tile display.
// It generates the sync timing and finds the tile under each pixel with
// incremental counters, so the scan path has no multipliers. It then forms
// the tile-ROM read address and delays sync/valid to line up with ROM data.
//
// Ports:
//   pclk      pixel clock
//   rst_n     asynchronous active-low reset
//   tile_idx  image index for tile_pos (0 = empty), looked up combinationally
//   h_cnt     horizontal counter 0..799 (stage 0)
//   v_cnt     vertical counter 0..524 (stage 0)
//   tile_pos  tile 1..9 row-major, 0 = outside grid (stage 1)
//   tile_off  pixel offset inside the tile (stage 1)
//   rom_addr  tile-ROM read address (stage 2)
//   rom_en    rom_addr is a fresh read this cycle (stage 2)
//   hsync     active-low, aligned to ROM data (stage 3)
//   vsync     active-low, aligned to ROM data (stage 3)
//   px_valid  pixel lies in the 640x480 active area (stage 3)
//   px_tile   pixel lies on a non-empty tile; select ROM data (stage 3)
module vga_tile_scan #(
    parameter int TILE       = 130,
    parameter int TILE_WORDS = 16900,
    parameter int ROM_AW     = 20
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [15:0]       tile_idx,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt,
    output logic [3:0]        tile_pos,
    output logic [14:0]       tile_off,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    output logic              hsync,
    output logic              vsync,
    output logic              px_valid,
    output logic              px_tile
);

    localparam logic [9:0] H_MAX  = 10'd799;
    localparam logic [9:0] V_MAX  = 10'd524;
    localparam logic [9:0] H_ACT  = 10'd640;
    localparam logic [9:0] V_ACT  = 10'd480;
    localparam logic [9:0] HS_BEG = 10'd656;
    localparam logic [9:0] HS_END = 10'd751;
    localparam logic [9:0] VS_BEG = 10'd490;
    localparam logic [9:0] VS_END = 10'd491;
    localparam logic [9:0] GRID   = 10'(3 * TILE);
    localparam int         TW     = $clog2(TILE);
    localparam logic [TW-1:0] T_LAST = TW'(TILE - 1);
    localparam logic [14:0]   T_STEP = 15'(TILE);

    logic [TW-1:0] tx;
    logic [TW-1:0] ty;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [14:0]   row_base;

    logic          vld_p0, hs_p0, vs_p0, grid_p0;
    logic [3:0]    pos_p0;
    logic [14:0]   off_p0;

    logic          vld_p1, hs_p1, vs_p1, hit_p1;
    logic [ROM_AW-1:0] addr_p1;

    logic          vld_p2, hs_p2, vs_p2;

    // ---- stage 0: scan counters and incremental tile locator ----
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            tx       <= '0;
            col      <= '0;
            ty       <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            if (h_cnt == H_MAX) begin
                h_cnt <= '0;
                tx    <= '0;
                col   <= '0;
                if (v_cnt == V_MAX) begin
                    // frame wrap clear wins over the line advance
                    v_cnt    <= '0;
                    ty       <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                    if (v_cnt < GRID) begin
                        if (ty == T_LAST) begin
                            ty       <= '0;
                            row_base <= '0;
                            row      <= row + 2'd1;
                        end else begin
                            ty       <= ty + TW'(1);
                            row_base <= row_base + T_STEP;
                        end
                    end
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
                if (h_cnt < GRID) begin
                    if (tx == T_LAST) begin
                        tx  <= '0;
                        col <= col + 2'd1;
                    end else begin
                        tx <= tx + TW'(1);
                    end
                end
            end
        end
    end

    assign vld_p0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_p0   = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    assign vs_p0   = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    assign grid_p0 = (h_cnt < GRID) && (v_cnt < GRID);
    // row*3 as shift-and-add
    assign pos_p0  = grid_p0 ? (4'({row, 1'b0}) + 4'(row) + 4'(col) + 4'd1) : 4'd0;
    assign off_p0  = grid_p0 ? (row_base + 15'(tx)) : 15'd0;

    // ---- stage 1: tile position/offset ----
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            tile_pos <= '0;
            tile_off <= '0;
            vld_p1   <= 1'b0;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
        end else begin
            tile_pos <= pos_p0;
            tile_off <= off_p0;
            vld_p1   <= vld_p0;
            hs_p1    <= hs_p0;
            vs_p1    <= vs_p0;
        end
    end

    assign hit_p1  = (tile_pos != 4'd0) && (tile_idx != 16'd0);
    // constant multiply; wraps silently for indices past the ROM size
    assign addr_p1 = ROM_AW'(32'(tile_idx - 16'd1) * 32'(TILE_WORDS)) + ROM_AW'(tile_off);

    // ---- stage 2: ROM address ----
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
            vld_p2   <= 1'b0;
            hs_p2    <= 1'b1;
            vs_p2    <= 1'b1;
        end else begin
            if (hit_p1) begin
                rom_addr <= addr_p1;
            end
            rom_en <= hit_p1;
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    // ---- stage 3: aligned with ROM read data ----
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            px_valid <= 1'b0;
            px_tile  <= 1'b0;
        end else begin
            hsync    <= hs_p2;
            vsync    <= vs_p2;
            px_valid <= vld_p2;
            px_tile  <= rom_en && vld_p2;
        end
    end

endmodule

// File: tb/tb_vga_tile_scan.sv
module tb_vga_tile_scan;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] idx_a, idx_b;

    logic [9:0]  h_a, v_a, h_b, v_b;
    logic [3:0]  pos_a, pos_b;
    logic [14:0] off_a, off_b;
    logic [19:0] addr_a, addr_b;
    logic        en_a, en_b, hs_a, hs_b, vs_a, vs_b, pv_a, pv_b, pt_a, pt_b;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    vga_tile_scan dut_a (
        .pclk(pclk), .rst_n(rst_n), .tile_idx(idx_a),
        .h_cnt(h_a), .v_cnt(v_a), .tile_pos(pos_a), .tile_off(off_a),
        .rom_addr(addr_a), .rom_en(en_a), .hsync(hs_a), .vsync(vs_a),
        .px_valid(pv_a), .px_tile(pt_a)
    );

    // reduced tile edge so all nine tiles are scanned within a short run
    vga_tile_scan #(.TILE(20), .TILE_WORDS(400), .ROM_AW(20)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .tile_idx(idx_b),
        .h_cnt(h_b), .v_cnt(v_b), .tile_pos(pos_b), .tile_off(off_b),
        .rom_addr(addr_b), .rom_en(en_b), .hsync(hs_b), .vsync(vs_b),
        .px_valid(pv_b), .px_tile(pt_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: pixel position p (cycles since reset release)
    function automatic int hp(longint p);
        return int'(p % 800);
    endfunction
    function automatic int vp(longint p);
        return int'((p / 800) % 525);
    endfunction
    function automatic int m_pos(int t, longint p);
        int h, v;
        if (p < 0) return 0;
        h = hp(p); v = vp(p);
        if (h < 3 * t && v < 3 * t) return (v / t) * 3 + h / t + 1;
        return 0;
    endfunction
    function automatic int m_off(int t, longint p);
        if (m_pos(t, p) == 0) return 0;
        return (vp(p) % t) * t + hp(p) % t;
    endfunction
    function automatic int m_act(longint p);
        if (p < 0) return 0;
        return (hp(p) < 640 && vp(p) < 480) ? 1 : 0;
    endfunction
    function automatic int m_hs(longint p);
        if (p < 0) return 1;
        return (hp(p) >= 656 && hp(p) <= 751) ? 0 : 1;
    endfunction
    function automatic int m_vs(longint p);
        if (p < 0) return 1;
        return (vp(p) == 490 || vp(p) == 491) ? 0 : 1;
    endfunction

    function automatic logic [15:0] pick_idx();
        int r;
        r = $urandom_range(0, 7);
        if (r < 2) return 16'd0;
        if (r < 6) return 16'($urandom_range(1, 9));
        if (r < 7) return 16'($urandom_range(10, 62));
        return 16'($urandom);
    endfunction

    task automatic check_inst(input string nm, input int t, input int tw, input longint k,
                              input logic [15:0] idx_prev,
                              inout logic [19:0] addr_m, inout logic en_m,
                              input logic [9:0] h, input logic [9:0] v,
                              input logic [3:0] pos, input logic [14:0] off,
                              input logic [19:0] addr, input logic en,
                              input logic hs, input logic vs, input logic pv, input logic pt);
        logic en_old;
        longint a;
        en_old = en_m;
        if (m_pos(t, k - 2) != 0 && idx_prev != 16'd0) begin
            a = (longint'(idx_prev) - 1) * tw + m_off(t, k - 2);
            addr_m = 20'(a % (longint'(1) << 20));
            en_m = 1'b1;
        end else begin
            en_m = 1'b0;
        end
        check_val({nm, ".h_cnt"}, 32'(h), 32'(hp(k)));
        check_val({nm, ".v_cnt"}, 32'(v), 32'(vp(k)));
        check_val({nm, ".tile_pos"}, 32'(pos), 32'(m_pos(t, k - 1)));
        check_val({nm, ".tile_off"}, 32'(off), 32'(m_off(t, k - 1)));
        check_val({nm, ".rom_addr"}, 32'(addr), 32'(addr_m));
        check_val({nm, ".rom_en"}, 32'(en), 32'(en_m));
        check_val({nm, ".hsync"}, 32'(hs), 32'(m_hs(k - 3)));
        check_val({nm, ".vsync"}, 32'(vs), 32'(m_vs(k - 3)));
        check_val({nm, ".px_valid"}, 32'(pv), 32'(m_act(k - 3)));
        check_val({nm, ".px_tile"}, 32'((en_old == 1'b1) && (m_act(k - 3) == 1)), 32'(pt));
    endtask

    task automatic check_reset(input string nm);
        check_val({nm, ".a.h_cnt"}, 32'(h_a), 32'd0);
        check_val({nm, ".a.v_cnt"}, 32'(v_a), 32'd0);
        check_val({nm, ".a.tile_pos"}, 32'(pos_a), 32'd0);
        check_val({nm, ".a.tile_off"}, 32'(off_a), 32'd0);
        check_val({nm, ".a.rom_addr"}, 32'(addr_a), 32'd0);
        check_val({nm, ".a.rom_en"}, 32'(en_a), 32'd0);
        check_val({nm, ".a.sync"}, 32'({hs_a, vs_a}), 32'd3);
        check_val({nm, ".a.px"}, 32'({pv_a, pt_a}), 32'd0);
        check_val({nm, ".b.cnt"}, 32'({h_b, v_b}), 32'd0);
        check_val({nm, ".b.tile"}, 32'({pos_b, off_b}), 32'd0);
        check_val({nm, ".b.rom"}, 32'({addr_b, en_b}), 32'd0);
        check_val({nm, ".b.out"}, 32'({hs_b, vs_b, pv_b, pt_b}), 32'b1100);
    endtask

    task automatic run_phase(input int n);
        logic [19:0] ma_addr, mb_addr;
        logic        ma_en, mb_en;
        logic [15:0] pa, pb;
        int          hs_low, pv_high;
        ma_addr = '0; mb_addr = '0; ma_en = 1'b0; mb_en = 1'b0;
        hs_low = 0; pv_high = 0;
        idx_a = pick_idx(); idx_b = pick_idx();
        for (int i = 1; i <= n; i++) begin
            @(posedge pclk);
            #1;
            pa = idx_a; pb = idx_b;
            check_inst("A", 130, 16900, longint'(i), pa, ma_addr, ma_en,
                       h_a, v_a, pos_a, off_a, addr_a, en_a, hs_a, vs_a, pv_a, pt_a);
            check_inst("B", 20, 400, longint'(i), pb, mb_addr, mb_en,
                       h_b, v_b, pos_b, off_b, addr_b, en_b, hs_b, vs_b, pv_b, pt_b);
            // directed constant points
            case (i)
                2:   begin check_val("addr_idx1_origin", 32'(addr_a), 32'd0);
                           check_val("en_idx1_origin", 32'(en_a), 32'd1); end
                130: check_val("tile_129_0", 32'({pos_a, off_a}), {13'd0, 4'd1, 15'd129});
                131: check_val("tile_130_0", 32'({pos_a, off_a}), {13'd0, 4'd2, 15'd0});
                132: check_val("addr_wrap_idx63", 32'(addr_a), 32'd1047800);
                391: check_val("tile_390_0", 32'({pos_a, off_a}), 32'd0);
                933: begin check_val("addr_idx3_131_1", 32'(addr_a), 32'd33931);
                           check_val("en_idx3_131_1", 32'(en_a), 32'd1); end
                934: check_val("px_tile_idx3", 32'(pt_a), 32'd1);
                4803: begin check_val("hsync_low_per_line", 32'(hs_low), 32'd96);
                            check_val("px_valid_per_line", 32'(pv_high), 32'd640); end
                16001: check_val("b_tile_0_20", 32'({pos_b, off_b}), {13'd0, 4'd4, 15'd0});
                47260: check_val("b_tile_59_59", 32'({pos_b, off_b}), {13'd0, 4'd9, 15'd399});
                48001: check_val("b_tile_0_60", 32'({pos_b, off_b}), 32'd0);
                default: ;
            endcase
            if (i >= 4003 && i < 4803) begin
                if (hs_a == 1'b0) hs_low++;
                if (pv_a == 1'b1) pv_high++;
            end
            // tile_idx for the pixel now in stage 1 (position i-1)
            if (i - 1 == 0)            idx_a = 16'd1;
            else if (i - 1 == 130)     idx_a = 16'd63;
            else if (i - 1 == 931)     idx_a = 16'd3;
            else                       idx_a = pick_idx();
            idx_b = (m_pos(20, longint'(i - 1)) == 5) ? 16'd0 : pick_idx();
        end
    endtask

    initial begin
        idx_a = '0;
        idx_b = '0;
        repeat (3) @(posedge pclk);
        #1 check_reset("rst_hold");
        @(negedge pclk) rst_n = 1'b1;
        run_phase(300);
        // asynchronous reset in the middle of a line
        @(posedge pclk);
        #3 rst_n = 1'b0;
        #1 check_reset("rst_async");
        repeat (2) @(posedge pclk);
        #1 check_reset("rst_held");
        @(negedge pclk) rst_n = 1'b1;
        run_phase(50000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
